seg7_scan_ctrl: RTL and testbench

Parametrised time-multiplexed driver for common-anode 7-segment displays with NDIG hex digits. Adds features the basic scanner lacks:
- proper reset
- frame-coherent snapshot of the displayed value
- per-digit enable and decimal point
- PWM brightness
- frame-start strobe
Sits between the system's value registers and the board's seg/an/dp pins.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_hex_decode.sv | 9 +
 rtl/seg7_scan_ctrl.sv | 105 ++++++++++
 tb/tb_seg7_scan_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment scan driver.
package seg7_pkg;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Segment order gfedcba, active-low (0 = lit).
  function automatic seg_t hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'h40;
      4'h1: hex2seg = 7'h79;
      4'h2: hex2seg = 7'h24;
      4'h3: hex2seg = 7'h30;
      4'h4: hex2seg = 7'h19;
      4'h5: hex2seg = 7'h12;
      4'h6: hex2seg = 7'h02;
      4'h7: hex2seg = 7'h78;
      4'h8: hex2seg = 7'h00;
      4'h9: hex2seg = 7'h10;
      4'hA: hex2seg = 7'h08;
      4'hB: hex2seg = 7'h03;
      4'hC: hex2seg = 7'h46;
      4'hD: hex2seg = 7'h21;
      4'hE: hex2seg = 7'h06;
      default: hex2seg = 7'h0E;
    endcase
  endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low gfedcba segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);
  assign seg = hex2seg(nib);
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment driver with frame-coherent snapshot,
// per-digit enable/dp and PWM brightness. Define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NDIG      = 8,
  parameter int DIV_BITS  = 17,
  parameter int DUTY_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NDIG-1:0]    value,
  input  logic [NDIG-1:0]      dp_in,
  input  logic [NDIG-1:0]      dig_en,
  input  logic [DUTY_BITS-1:0] bright,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [NDIG-1:0]      an,
  output logic                 frame_start
);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  logic [DIV_BITS-1:0]   div_cnt;
  logic [IW-1:0]         idx;
  logic                  snap_vld;
  logic [NDIG-1:0][3:0]  snap_val;
  logic [NDIG-1:0]       snap_dp, snap_en, lz_mask;
  logic                  tick, load, pwm_on, act;
  seg_t                  dec;

  assign tick   = &div_cnt;
  assign load   = !snap_vld || (tick && (idx == LAST));
  assign pwm_on = (div_cnt[DIV_BITS-1 -: DUTY_BITS] <= bright);
  assign act    = snap_vld && snap_en[idx] && pwm_on && !lz_mask[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if (tick) idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  // Inputs are only sampled here, so mid-frame changes wait for the next wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_vld    <= 1'b0;
      snap_val    <= '0;
      snap_dp     <= '0;
      snap_en     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load;
      if (load) begin
        snap_vld <= 1'b1;
        snap_val <= value;
        snap_dp  <= dp_in;
        snap_en  <= dig_en;
      end
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [NDIG-1:0] lz_next;
  logic            lz_run;

  // Blank from the top digit down until a non-zero nibble or a lit dp; digit 0 always shown.
  always_comb begin
    lz_next = '0;
    lz_run  = 1'b1;
    for (int k = NDIG - 1; k > 0; k--) begin
      lz_run     = lz_run && (value[4*k +: 4] == 4'h0) && !dp_in[k];
      lz_next[k] = lz_run;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       lz_mask <= '0;
    else if (load) lz_mask <= lz_next;
  end
`else
  assign lz_mask = '0;
`endif

  seg7_hex_decode u_dec (
    .nib (snap_val[idx]),
    .seg (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an <= '1;
      if (act) an[idx] <= 1'b0;
      seg <= act ? dec : SEG_BLANK;
      dp  <= act ? ~snap_dp[idx] : 1'b1;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized scoreboard bench for seg7_scan_ctrl (NDIG=4, DIV_BITS=4, DUTY_BITS=2).
module tb_seg7_scan_ctrl;
  localparam int NDIG = 4;
  localparam int DIV_BITS = 4;
  localparam int DUTY_BITS = 2;
  localparam int SLOT = 1 << DIV_BITS;
  localparam int FRAME = NDIG * SLOT;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [4*NDIG-1:0]    value;
  logic [NDIG-1:0]      dp_in, dig_en;
  logic [DUTY_BITS-1:0] bright;
  logic [6:0]           seg;
  logic                 dp;
  logic [NDIG-1:0]      an;
  logic                 frame_start;

  seg7_scan_ctrl #(.NDIG(NDIG), .DIV_BITS(DIV_BITS), .DUTY_BITS(DUTY_BITS)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .dig_en(dig_en),
    .bright(bright), .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NDIG-1:0] an;
    logic [6:0]      seg;
    logic            dp;
    logic            fs;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic logic [6:0] hexseg(input logic [3:0] h);
    logic [6:0] tab [16];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tab[h];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: k counts edges since reset release; slot/phase follow directly from it.
  initial begin : model
    int              k;
    int              d, p;
    logic            mv;
    logic [4*NDIG-1:0] mval;
    logic [NDIG-1:0] mdp, men, mlz;
    exp_t            e;
    k = 0; mv = 1'b0; mval = '0; mdp = '0; men = '0; mlz = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        k = 0; mv = 1'b0; q.delete();
      end else begin
        p = k % SLOT;
        d = (k / SLOT) % NDIG;
        e = '{an: '1, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
        if (mv && men[d] && !mlz[d] && (p / (SLOT >> DUTY_BITS) <= int'(bright))) begin
          e.an  = ~(NDIG'(1) << d);
          e.seg = hexseg(mval[4*d +: 4]);
          e.dp  = ~mdp[d];
        end
        e.fs = !mv || (k % FRAME == FRAME - 1);
        if (e.fs) begin
          mv = 1'b1; mval = value; mdp = dp_in; men = dig_en; mlz = '0;
`ifdef SEG7_LZ_BLANK_EN
          for (int j = NDIG - 1; j > 0; j--) begin
            if (value[4*j +: 4] != 4'h0 || dp_in[j]) break;
            mlz[j] = 1'b1;
          end
`endif
        end
        q.push_back(e);
        k++;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        chk("an", 32'(an), 32'(e.an));
        chk("seg", 32'(seg), 32'(e.seg));
        chk("dp", 32'(dp), 32'(e.dp));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end
  end

  task automatic apply(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en,
                       input logic [1:0] b, input int cycles);
    value = v; dp_in = d; dig_en = en; bright = b;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin : stim
    rst = 1'b1; value = '0; dp_in = '0; dig_en = '1; bright = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    apply(16'h1234, 4'h0, 4'hF, 2'd3, FRAME + 20);
    apply(16'hABCD, 4'h0, 4'hF, 2'd3, 2 * FRAME);
    apply(16'h1234, 4'h0, 4'hF, 2'd0, 2 * FRAME);
    apply(16'h1234, 4'h0, 4'hF, 2'd1, 2 * FRAME);
    apply(16'h1234, 4'h4, 4'h5, 2'd3, 2 * FRAME);
    apply(16'h0070, 4'h0, 4'hF, 2'd3, 2 * FRAME);
    apply(16'h0000, 4'h0, 4'hF, 2'd3, 2 * FRAME);
    apply(16'h0000, 4'h8, 4'hF, 2'd3, 2 * FRAME);

    // Asynchronous reset mid-scan: outputs must clear without a clock edge.
    repeat (37) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_fs", 32'(frame_start), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        value = {$urandom_range(0, 15), 12'h000} >> (4 * $urandom_range(0, 3));
      else
        value = 16'($urandom);
      dp_in  = 4'($urandom);
      dig_en = 4'($urandom);
      bright = 2'($urandom);
      repeat ($urandom_range(1, 90)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
